// File: rtl/ofifo_pkg.sv
// rtl/ofifo_pkg.sv - shared constants and helpers for the output FIFO collector
package ofifo_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int DEPTH_DEF   = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int PTR_W = clog2(DEPTH_DEF) + 1;

endpackage

// File: rtl/fifo_col.sv
// rtl/fifo_col.sv - single-column first-word-fall-through FIFO
module fifo_col
  import ofifo_pkg::*;
#(
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               rd,
  input  logic [PSUM_BW-1:0] in,
  output logic [PSUM_BW-1:0] out,
  output logic               empty,
  output logic               full
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_INC = PW'(1);

  logic [PSUM_BW-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic               w_wr_ok;
  logic               w_rd_ok;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign empty   = (r_wptr == r_rptr);
  assign full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_wr_ok = wr && !full;
  assign w_rd_ok = rd && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + PTR_INC;
      if (w_rd_ok) r_rptr <= r_rptr + PTR_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr[AW-1:0]] <= in;
  end

  assign out = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ofifo_collector.sv
// rtl/ofifo_collector.sv - per-column psum buffering that releases only complete aligned rows
module ofifo_collector
  import ofifo_pkg::*;
#(
  parameter int COL     = COL_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COL-1:0]         wr,
  input  logic [COL*PSUM_BW-1:0] in,
  input  logic                   rd,
  output logic [COL*PSUM_BW-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  logic [COL-1:0]     w_empty;
  logic [COL-1:0]     w_full;
  logic [PSUM_BW-1:0] w_col_out [COL];
  logic               w_pop;
  logic               r_overflow;

  // A row pops only when every column has an entry, so columns never drift apart.
  assign w_pop = rd && o_valid;

  genvar c;
  generate
    for (c = 0; c < COL; c++) begin : g_col
      fifo_col #(
        .PSUM_BW (PSUM_BW),
        .DEPTH   (DEPTH)
      ) u_col (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr[c]),
        .rd    (w_pop),
        .in    (in[c*PSUM_BW +: PSUM_BW]),
        .out   (w_col_out[c]),
        .empty (w_empty[c]),
        .full  (w_full[c])
      );

      assign out[c*PSUM_BW +: PSUM_BW] = o_valid ? w_col_out[c] : '0;
    end
  endgenerate

  assign o_valid    = ~|w_empty;
  assign o_full     = |w_full;
  assign o_ready    = ~o_full;
  assign o_overflow = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (|(wr & w_full)) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/ofifo_collector.md
Name: ofifo_collector

Overview:
- Multi-column output FIFO between the MAC array's bottom-row psum outputs and the per-column accumulate/ReLU stage (sfu).
- Each array column produces psums at its own skewed time. This block buffers them per column.
- It presents a complete aligned row only when every column has data.
- Read is first-word-fall-through: the sfu can take the row on the same edge that pops it (rd drives sfu acc_valid).

Parameters:
- COL, 8, number of array columns / sfu instances.
- PSUM_BW, 16, signed psum width per column.
- DEPTH, 64, entries per column FIFO; power of 2, ≥2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- wr  input  COL  per-column write strobe; bit c writes in slice c.
- in  input  COL*PSUM_BW  column psums; column c at bits [(c+1)*PSUM_BW-1 : c*PSUM_BW].
- rd  input  1  pop one entry from every column.
- out  output  COL*PSUM_BW  head row, same packing as in.
- o_valid  output  1  all columns non-empty.
- o_full  output  1  at least one column full.
- o_ready  output  1  no column full (equals !o_full).
- o_overflow  output  1  sticky: a write hit a full column.

Behaviour:
- Per-column storage: DEPTH×PSUM_BW array; write pointer and read pointer each log2(DEPTH)+1 bits.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- Reset (async, any time including mid-transfer):
  - All pointers 0, o_overflow 0.
  - Therefore o_valid 0, o_full 0, o_ready 1, out 0.
  - Storage contents are not reset and are never observable.
- Write:
  - On posedge, for each c with wr[c]=1 and column c not full (pre-edge state): store slice c at wptr, wptr+1.
  - Write to a full column: data dropped, wptr unchanged, o_overflow←1. o_overflow stays set until rst.
  - An rd on the same edge does not rescue a write to a full column; full is evaluated pre-edge.
- Read:
  - On posedge with rd=1 and o_valid=1 (pre-edge): every column's rptr+1.
  - rd with o_valid=0: ignored, no pointer moves, no error flag.
  - Read never partially pops.
- Same column, same edge, wr and rd both accepted: count unchanged, both pointers advance.
- Write to an empty column while rd is high: the write is accepted. The read is ignored unless all columns were non-empty pre-edge.
- Output, combinational from registered state:
  - out slice c = mem_c[rptr_c] when o_valid, else 0. Zero-gating keeps the sfu fed with harmless data.
  - o_valid = AND of all column non-empty flags.
  - o_full = OR of full flags.
  - Write-to-out latency: 1 cycle. Data written at edge N is visible on out after edge N if all columns are then non-empty.
- Flags are derived from pointers only; there are no separate counters to diverge.
- Back-pressure: the upstream array controller stalls while o_ready=0. The block does not stall upstream itself.

Decomposition:
- Shared package ofifo_pkg:
  - default constants COL_DEF=8, PSUM_BW_DEF=16, DEPTH_DEF=64.
  - function clog2.
  - pointer-width localparam PTR_W = clog2(DEPTH)+1.
- One natural sub-module: fifo_col.
  - Single-column FWFT FIFO: ports clk, rst, wr, rd, in, out, empty, full.
  - The top instantiates COL copies in a generate loop, drives each with the global pop (rd & o_valid), and does flag reduction, output gating and overflow tracking.

Test Plan:
1. Skewed fill:
   - Stimulus: COL=8; write column c at cycle c with value 100+c.
   - Response: o_valid stays 0 until after the column-7 write edge, then 1; out = {107,…,100}.
   - Next: rd 1 cycle → o_valid 0, out 0.
2. Illegal read:
   - Stimulus: only columns 0–6 hold data; assert rd.
   - Response: nothing pops; after column 7 is written, out shows the original column 0–6 values.
3. Full and overflow, column 3 only:
   - Stimulus: DEPTH=4; write 1,2,3,4 to column 3.
   - Response: o_full=1, o_ready=0.
   - Stimulus: 5th write value 99.
   - Response: o_overflow=1; column 3 still pops 1,2,3,4 in order (other columns pre-filled).
4. Simultaneous read/write:
   - Stimulus: all columns hold 2 entries; assert rd and wr=all-ones for 10 cycles with values −1…−10.
   - Response: occupancy stays 2; popped sequence = the 2 old rows, then −1…−8.
5. Pointer wrap:
   - Stimulus: DEPTH=4; stream 20 rows with value=row index, rd whenever o_valid.
   - Response: out sequence is 0..19 exactly; o_full never 1 with single-entry occupancy.
6. Async reset mid-stream:
   - Stimulus: 3 rows buffered, o_overflow=1; pulse rst between clock edges.
   - Response: immediately o_valid=0, out=0, o_overflow=0, o_ready=1; a subsequent single-row write then reads back correctly.
